// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection default and the
// initiator state type.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] PROT_DEFAULT = 3'b000;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_REQ,
      WR_RESP,
      DONE
   } axi_state_e;

   function automatic logic resp_is_err(input logic [1:0] resp);
      case (resp)
         RESP_OKAY, RESP_EXOKAY:   return 1'b0;
         RESP_SLVERR, RESP_DECERR: return 1'b1;
         default:                  return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator for the memory stage.
// Optional macro AXI_MASTER_MISALIGN_CHECK_EN rejects non-word-aligned requests locally.
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err,

   output logic [ADDR_W-1:0]   m_axi_araddr,
   output logic                m_axi_arvalid,
   output logic [2:0]          m_axi_arprot,
   input  logic                m_axi_arready,
   input  logic [DATA_W-1:0]   m_axi_rdata,
   input  logic [1:0]          m_axi_rresp,
   input  logic                m_axi_rvalid,
   output logic                m_axi_rready,

   output logic [ADDR_W-1:0]   m_axi_awaddr,
   output logic                m_axi_awvalid,
   output logic [2:0]          m_axi_awprot,
   input  logic                m_axi_awready,
   output logic [DATA_W-1:0]   m_axi_wdata,
   output logic [DATA_W/8-1:0] m_axi_wstrb,
   output logic                m_axi_wvalid,
   input  logic                m_axi_wready,
   input  logic [1:0]          m_axi_bresp,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready
);

   axi_state_e state;
   logic       aw_done;
   logic       w_done;
   logic       aw_fire;
   logic       w_fire;
   logic       misaligned;

   assign m_axi_arprot = PROT_DEFAULT;
   assign m_axi_awprot = PROT_DEFAULT;
   assign aw_fire      = m_axi_awvalid && m_axi_awready;
   assign w_fire       = m_axi_wvalid && m_axi_wready;

`ifdef AXI_MASTER_MISALIGN_CHECK_EN
   assign misaligned = (req_addr[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // NOTE: every register here uses <= so all branches see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         resp_rdata    <= '0;
         resp_err      <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  if (misaligned) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     state      <= DONE;
                  end else if (req_we) begin
                     m_axi_awaddr  <= req_addr;
                     m_axi_wdata   <= req_wdata;
                     m_axi_wstrb   <= req_wstrb;
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                     aw_done       <= 1'b0;
                     w_done        <= 1'b0;
                     state         <= WR_REQ;
                  end else begin
                     m_axi_araddr  <= req_addr;
                     m_axi_arvalid <= 1'b1;
                     state         <= RD_ADDR;
                  end
               end
            end
            RD_ADDR: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
                  state         <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (m_axi_rvalid) begin
                  m_axi_rready <= 1'b0;
                  resp_rdata   <= m_axi_rdata;
                  resp_err     <= resp_is_err(m_axi_rresp);
                  resp_valid   <= 1'b1;
                  state        <= DONE;
               end
            end
            WR_REQ: begin
               // AW and W retire independently; the flags remember which already did.
               if (aw_fire) begin
                  m_axi_awvalid <= 1'b0;
                  aw_done       <= 1'b1;
               end
               if (w_fire) begin
                  m_axi_wvalid <= 1'b0;
                  w_done       <= 1'b1;
               end
               if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                  m_axi_bready <= 1'b1;
                  state        <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (m_axi_bvalid) begin
                  m_axi_bready <= 1'b0;
                  resp_err     <= resp_is_err(m_axi_bresp);
                  resp_valid   <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_master.sv
// Randomized bench for axi_lite_master: a transaction-level timing model predicts
// every output each cycle; build with AXI_MASTER_MISALIGN_CHECK_EN to cover rejection.
module tb_axi_lite_master;
   import axi_lite_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] araddr, awaddr, wdata, rdata;
   logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
   logic [2:0]  arprot, awprot;
   logic [3:0]  wstrb;
   logic [1:0]  rresp, bresp;

   axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arprot(arprot),
      .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready),
      .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awprot(awprot),
      .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
      .m_axi_bvalid(bvalid), .m_axi_bready(bready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {K_RD, K_WR, K_MIS} kind_e;
   typedef struct {
      kind_e       kind;
      int          d0, d1, d2;   // RD: ar wait, r wait.  WR: aw wait, w wait, b wait.
      logic [31:0] addr, wdata, rdata;
      logic [3:0]  wstrb;
      logic [1:0]  resp;
      int          rst_k;        // cycle after accept in which rst is raised, 0 = never
      int          gap;          // idle cycles before the next request
   } plan_t;

   plan_t       q[$];
   plan_t       cur;
   bit          busy = 0;
   int          acc = 0;
   int          gap = 1;
   int          cur_id = -1;
   logic [31:0] last_rdata = '0;
   int          vectors = 0;
   int          miscompares = 0;

   int obs_resp_k[16], obs_resp_cyc[16], obs_rv_cnt[16], obs_ar[16], obs_aw[16], obs_w[16];
   int obs_b_first[16], obs_acc[16];
   logic [31:0] obs_rdata[16];
   logic        obs_err[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic int maxi(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Cycle, counted from the accept edge, in which resp_valid must be high.
   function automatic int resp_k(input plan_t p);
      case (p.kind)
         K_RD:    return 3 + p.d0 + p.d1;
         K_WR:    return 3 + maxi(p.d0, p.d1) + p.d2;
         default: return 1;
      endcase
   endfunction

   function automatic bit in_win(input int k, input int s, input int e);
      return (k >= s) && (k <= e);
   endfunction

   function automatic logic noise();
      return $urandom_range(0, 3) == 0;
   endfunction

   // Handshake input that fires exactly at cycle t; random junk is allowed only
   // outside [s,t], where the master is not offering the matching valid/ready.
   function automatic logic drv(input int k, input int s, input int t);
      return (k == t) || (noise() && (k < s || k > t));
   endfunction

   task automatic cycle();
      int  k, m;
      bit  e_ar, e_r, e_aw, e_w, e_b, e_resp, err;
      @(negedge clk);
      k = cyc - acc;
      m = maxi(cur.d0, cur.d1);
      {e_ar, e_r, e_aw, e_w, e_b, e_resp} = '0;
      if (busy) begin
         if (cur.kind == K_RD) begin
            e_ar = in_win(k, 1, 1 + cur.d0);
            e_r  = in_win(k, 2 + cur.d0, 2 + cur.d0 + cur.d1);
         end else if (cur.kind == K_WR) begin
            e_aw = in_win(k, 1, 1 + cur.d0);
            e_w  = in_win(k, 1, 1 + cur.d1);
            e_b  = in_win(k, 2 + m, 2 + m + cur.d2);
         end
         e_resp = (k == resp_k(cur));
         if (e_resp && cur.kind == K_RD) last_rdata = cur.rdata;
      end
      check("req_ready", req_ready, !busy);
      check("resp_valid", resp_valid, e_resp);
      check("arvalid", arvalid, e_ar);
      check("rready", rready, e_r);
      check("awvalid", awvalid, e_aw);
      check("wvalid", wvalid, e_w);
      check("bready", bready, e_b);
      check("arprot", arprot, 3'b000);
      check("awprot", awprot, 3'b000);
      check("resp_rdata", resp_rdata, last_rdata);
      if (e_ar) check("araddr", araddr, cur.addr);
      if (e_aw) check("awaddr", awaddr, cur.addr);
      if (e_w) begin
         check("wdata", wdata, cur.wdata);
         check("wstrb", wstrb, cur.wstrb);
      end
      if (e_resp) begin
         err = (cur.kind == K_MIS) || cur.resp == RESP_SLVERR || cur.resp == RESP_DECERR;
         check("resp_err", resp_err, err);
      end

      if (cur_id >= 0 && cur_id < 16) begin
         if (resp_valid) begin
            obs_resp_k[cur_id]   = k;
            obs_resp_cyc[cur_id] = cyc;
            obs_rv_cnt[cur_id]++;
            obs_err[cur_id]      = resp_err;
            obs_rdata[cur_id]    = resp_rdata;
         end
         if (arvalid) obs_ar[cur_id]++;
         if (awvalid) obs_aw[cur_id]++;
         if (wvalid)  obs_w[cur_id]++;
         if (bready && obs_b_first[cur_id] < 0) obs_b_first[cur_id] = k;
      end

      // Slave side for this cycle.
      rst   = 1'b0;
      rdata = $urandom;
      rresp = 2'($urandom_range(0, 3));
      bresp = 2'($urandom_range(0, 3));
      {arready, rvalid, awready, wready, bvalid} = {noise(), noise(), noise(), noise(), noise()};
      if (busy && cur.kind == K_RD) begin
         arready = drv(k, 1, 1 + cur.d0);
         rvalid  = drv(k, 2 + cur.d0, 2 + cur.d0 + cur.d1);
         if (k == 2 + cur.d0 + cur.d1) begin
            rdata = cur.rdata;
            rresp = cur.resp;
         end
      end else if (busy && cur.kind == K_WR) begin
         awready = drv(k, 1, 1 + cur.d0);
         wready  = drv(k, 1, 1 + cur.d1);
         bvalid  = drv(k, 2 + m, 2 + m + cur.d2);
         if (k == 2 + m + cur.d2) bresp = cur.resp;
      end

      // Request side for this cycle.
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_wstrb = 4'($urandom_range(0, 15));
      if (busy) begin
         if (cur.rst_k == k) begin
            rst        = 1'b1;
            busy       = 0;
            last_rdata = '0;
         end else if (e_resp) begin
            busy = 0;
         end
      end else if (gap == 0 && q.size() > 0) begin
         cur = q.pop_front();
         cur_id++;
         req_valid = 1'b1;
         req_we    = (cur.kind == K_WR);
         req_addr  = cur.addr;
         req_wdata = cur.wdata;
         req_wstrb = cur.wstrb;
         acc       = cyc;
         busy      = 1;
         gap       = cur.gap;
         if (cur_id < 16) obs_acc[cur_id] = cyc;
      end else begin
         req_valid = 1'b0;
         if (gap > 0) gap--;
      end
   endtask

   function automatic plan_t mk(input kind_e kind, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [3:0] ws, input logic [31:0] rd, input logic [1:0] resp,
                                input int d0, input int d1, input int d2, input int rst_k,
                                input int g);
      plan_t p;
      p.kind = kind; p.addr = addr; p.wdata = wd; p.wstrb = ws; p.rdata = rd; p.resp = resp;
      p.d0 = d0; p.d1 = d1; p.d2 = d2; p.rst_k = rst_k; p.gap = g;
      return p;
   endfunction

   function automatic plan_t rand_plan();
      plan_t p;
      p.addr = $urandom;
`ifdef AXI_MASTER_MISALIGN_CHECK_EN
      if ($urandom_range(0, 3) != 0) p.addr[1:0] = 2'b00;
`endif
      p.kind = ($urandom_range(0, 1) == 1) ? K_WR : K_RD;
`ifdef AXI_MASTER_MISALIGN_CHECK_EN
      if (p.addr[1:0] != 2'b00) p.kind = K_MIS;
`endif
      p.d0    = $urandom_range(0, 3);
      p.d1    = $urandom_range(0, 3);
      p.d2    = $urandom_range(0, 3);
      p.wdata = $urandom;
      p.rdata = $urandom;
      p.wstrb = 4'($urandom_range(0, 15));
      p.resp  = 2'($urandom_range(0, 3));
      p.gap   = $urandom_range(0, 2);
      p.rst_k = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, resp_k(p))) : 0;
      return p;
   endfunction

   task automatic drain(input string name);
      for (int i = 0; i < 5000 && (busy || q.size() > 0); i++) cycle();
      check(name, 32'(busy || q.size() > 0), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         obs_resp_k[i] = -1; obs_resp_cyc[i] = -1; obs_rv_cnt[i] = 0; obs_ar[i] = 0;
         obs_aw[i] = 0; obs_w[i] = 0; obs_b_first[i] = -1; obs_acc[i] = -1;
         obs_rdata[i] = '0; obs_err[i] = 1'b0;
      end
      rst = 1'b1;
      {req_valid, req_we, req_addr, req_wdata, req_wstrb} = '0;
      {arready, rvalid, awready, wready, bvalid, rdata, rresp, bresp} = '0;
      repeat (2) @(posedge clk);

      q.push_back(mk(K_RD, 32'h0000_0040, 32'h0, 4'h0, 32'hDEADBEEF, RESP_OKAY, 0, 0, 0, 0, 1));
      q.push_back(mk(K_WR, 32'h0000_0100, 32'h12345678, 4'b0011, 32'h0, RESP_OKAY, 3, 0, 0, 0, 1));
      q.push_back(mk(K_RD, 32'h0000_0200, 32'h0, 4'h0, 32'hCAFE0001, RESP_SLVERR, 0, 2, 0, 0, 1));
      q.push_back(mk(K_WR, 32'h0000_0300, 32'hA5A5A5A5, 4'hF, 32'h0, RESP_OKAY, 0, 1, 4, 4, 0));
      q.push_back(mk(K_RD, 32'h0000_0404, 32'h0, 4'h0, 32'h0BADF00D, RESP_OKAY, 0, 0, 0, 0, 0));
      q.push_back(mk(K_WR, 32'h0000_0408, 32'h55AA33CC, 4'b1100, 32'h0, RESP_EXOKAY, 0, 0, 0, 0, 2));
`ifdef AXI_MASTER_MISALIGN_CHECK_EN
      q.push_back(mk(K_MIS, 32'h0000_0102, 32'h0, 4'h0, 32'h0, RESP_OKAY, 0, 0, 0, 0, 1));
`endif
      drain("directed_drain");

      check("lit_rd_latency", obs_resp_k[0], 3);
      check("lit_rd_data", obs_rdata[0], 32'hDEADBEEF);
      check("lit_rd_err", obs_err[0], 0);
      check("lit_wr_aw_cycles", obs_aw[1], 4);
      check("lit_wr_w_cycles", obs_w[1], 1);
      check("lit_wr_bready_first", obs_b_first[1], 5);
      check("lit_wr_latency", obs_resp_k[1], 6);
      check("lit_wr_err", obs_err[1], 0);
      check("lit_rderr_err", obs_err[2], 1);
      check("lit_rderr_latency", obs_resp_k[2], 5);
      check("lit_rderr_pulse", obs_rv_cnt[2], 1);
      check("lit_rst_no_resp", obs_rv_cnt[3], 0);
      check("lit_after_rst_rd", obs_rdata[4], 32'h0BADF00D);
      check("lit_b2b_accept", obs_acc[5] - obs_resp_cyc[4], 1);
      check("lit_b2b_period", obs_acc[5] - obs_acc[4], 4);
`ifdef AXI_MASTER_MISALIGN_CHECK_EN
      check("lit_mis_latency", obs_resp_k[6], 1);
      check("lit_mis_no_ar", obs_ar[6], 0);
      check("lit_mis_err", obs_err[6], 1);
      check("lit_mis_rdata_kept", obs_rdata[6], 32'h0BADF00D);
`endif

      for (int i = 0; i < 200; i++) q.push_back(rand_plan());
      drain("random_drain");
      repeat (3) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
